nco_quad: RTL and testbench
===========================

Name: nco_quad

Overview:
- Numerically controlled oscillator producing signed quadrature sine/cosine samples.
- It is the address-issuing initiator for the 1024 x 18 dual-port half-sine ROM (Sine1k2h):
  - Port A serves sine; port B serves cosine.
  - The ROM returns unsigned magnitude over 0..pi with 2-cycle read latency.
- Sits between the DDS frequency/phase control registers and the mixer/modulator datapath.

Parameters:
- PW, 32, phase accumulator / frequency word width (>= 12).

Ports:
- clk  in  1  common clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance accumulator and emit one sample this cycle
- sync  in  1  zero phase accumulator
- freq  in  PW  phase increment per enabled cycle, unsigned
- phase_ofs  in  PW  phase offset added before lookup
- rom_aa  out  10  ROM port A address (sine)
- rom_ab  out  10  ROM port B address (cosine)
- rom_da  in  18  ROM port A data, unsigned magnitude, valid 2 cycles after rom_aa
- rom_db  in  18  ROM port B data, as rom_da
- sin_out  out  19  signed sine sample, two's complement
- cos_out  out  19  signed cosine sample
- valid  out  1  sin_out/cos_out hold a new sample this cycle

Behaviour:
- rst_n low, asynchronous: clears acc, rom_aa, rom_ab, all sign/valid pipeline bits, sin_out, cos_out and valid to 0.
- Release of rst_n is synchronised externally; no output is valid until en is seen after reset.
- Phase, sampled at edge k when en=1 and sync=0:
  - P = acc + phase_ofs (mod 2^PW), using the pre-increment acc.
  - Q = P + 2^(PW-2) (quarter turn).
- Stage 1 (edge k):
  - rom_aa <= P[PW-2:PW-11]; sgn_s1 <= P[PW-1]
  - rom_ab <= Q[PW-2:PW-11]; sgn_c1 <= Q[PW-1]
  - v1 <= 1; acc <= acc + freq, wraps mod 2^PW.
- en=0 at an edge:
  - acc holds, v1 <= 0.
  - rom_aa/rom_ab hold their previous value.
- sync=1 at an edge: acc <= 0 and v1 <= 0, regardless of en. The next enabled cycle uses acc=0.
- Edges k+1, k+2:
  - ROM pipeline: address latch, then output register.
  - sign and valid bits shift in lockstep: s1->s2->s3, v1->v2->v3.
- Edge k+3:
  - If v3=1: sin_out <= sgn ? -{0,rom_da} : {0,rom_da}, 19-bit; cos_out likewise from rom_db; valid <= 1.
  - If v3=0: outputs hold, valid <= 0.
- Fixed latency is 3 cycles from the en edge to the valid edge.
- Throughput is one sample per clock; the pipeline never stalls.
- Magnitude 0 with sign 1 yields 0. The maximum magnitude 0x3FFFF yields ±262143; there is no overflow in 19 bits.
- freq and phase_ofs are sampled on every enabled edge. Changes take effect on the next sample with no glitch; phase continuity is preserved across freq changes.
- Truncation only: the low PW-11 phase bits are discarded. No rounding or dither.
- Reset asserted mid-stream: in-flight samples are discarded and valid drops immediately (asynchronously).

Test Plan:
- Reset, then en=1 continuous, freq=2^21, ofs=0 -> after 3 cycles:
  - valid=1, sin_out = 0, 804 (0x324), ...
  - cos_out first = 262143 (ROM[512]=0x3FFFF).
  - rom_aa steps 0,1,2,... and wraps 1023->0 with sin sign flipping negative at that wrap.
- freq=2^31, en=1 ->
  - sin_out = 0,0,0...
  - cos_out alternates +262143 / -262143 every cycle.
- ofs=0x80000000 vs ofs=0 with identical freq -> every sin_out/cos_out is the exact negation (0 stays 0); latency unchanged.
- en pattern 1,0,0,1,1 with freq=2^21 ->
  - valid pattern 1,0,0,1,1 delayed 3 cycles.
  - Outputs hold during gaps; phases are 0,1,2 steps (no advance when en=0).
- sync pulse mid-stream with en=1 that cycle -> that cycle produces no sample; next sample is phase 0 (sin_out=0, cos_out=262143).
- rst_n asserted asynchronously between clock edges while valid=1 -> sin_out, cos_out and valid go to 0 before the next edge; after release, the first valid appears 3 cycles after the first en.

Source files
------------

// File: rtl/nco_quad.sv
// nco_quad: quadrature NCO that addresses an external 1024 x 18 dual-port
// half-sine ROM (2-cycle read latency) and applies the half-wave sign bit.
// Sine comes from ROM port A, cosine from port B.
// The fixed latency is 3 clocks from an enabled edge to the matching valid edge.
module nco_quad #(
  parameter int PW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync,
  input  logic [PW-1:0]       freq,
  input  logic [PW-1:0]       phase_ofs,
  output logic [9:0]          rom_aa,
  output logic [9:0]          rom_ab,
  input  logic [17:0]         rom_da,
  input  logic [17:0]         rom_db,
  output logic signed [18:0]  sin_out,
  output logic signed [18:0]  cos_out,
  output logic                valid
);

  // A quarter turn of phase. It is added so that port B reads cosine.
  localparam logic [PW-1:0] QUARTER = {2'b01, {(PW-2){1'b0}}};

  // Turns the unsigned ROM magnitude into a signed sample. Negating 0 gives 0.
  // The 19-bit result always holds +/-262143, so no saturation is needed.
  function automatic logic signed [18:0] apply_sign(input logic sgn,
                                                    input logic [17:0] mag);
    logic signed [18:0] m;
    m = signed'({1'b0, mag});
    return sgn ? -m : m;
  endfunction

  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      phase_p0;
  logic [PW-1:0]      quad_p0;
  logic [9:0]         rom_aa_q, rom_aa_d;
  logic [9:0]         rom_ab_q, rom_ab_d;
  logic               sgn_s_p1_q, sgn_s_p1_d;
  logic               sgn_c_p1_q, sgn_c_p1_d;
  logic               vld_p1_q, vld_p1_d;
  logic               sgn_s_p2_q, sgn_c_p2_q, vld_p2_q;
  logic               sgn_s_p3_q, sgn_c_p3_q, vld_p3_q;
  logic signed [18:0] sin_q, sin_d;
  logic signed [18:0] cos_q, cos_d;
  logic               valid_q, valid_d;

  // Stage 0: build the lookup phase from the accumulator value before it is incremented.
  assign phase_p0 = acc_q + phase_ofs;
  assign quad_p0  = phase_p0 + QUARTER;

  // Next state for the accumulator and stage 1. Sync overrides en.
  // While en is low, the ROM addresses keep their previous value.
  always_comb begin
    acc_d      = acc_q;
    rom_aa_d   = rom_aa_q;
    rom_ab_d   = rom_ab_q;
    sgn_s_p1_d = sgn_s_p1_q;
    sgn_c_p1_d = sgn_c_p1_q;
    vld_p1_d   = 1'b0;
    if (sync) begin
      acc_d = '0;
    end else if (en) begin
      acc_d      = acc_q + freq;
      rom_aa_d   = phase_p0[PW-2 -: 10];
      rom_ab_d   = quad_p0[PW-2 -: 10];
      sgn_s_p1_d = phase_p0[PW-1];
      sgn_c_p1_d = quad_p0[PW-1];
      vld_p1_d   = 1'b1;
    end
  end

  // Stage 1 registers: the accumulator, the ROM addresses and the first sign/valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      rom_aa_q   <= '0;
      rom_ab_q   <= '0;
      sgn_s_p1_q <= 1'b0;
      sgn_c_p1_q <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      rom_aa_q   <= rom_aa_d;
      rom_ab_q   <= rom_ab_d;
      sgn_s_p1_q <= sgn_s_p1_d;
      sgn_c_p1_q <= sgn_c_p1_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  // Stages 2-3: the sign and valid bits move in step with the ROM's two read stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_s_p2_q <= 1'b0;
      sgn_c_p2_q <= 1'b0;
      vld_p2_q   <= 1'b0;
      sgn_s_p3_q <= 1'b0;
      sgn_c_p3_q <= 1'b0;
      vld_p3_q   <= 1'b0;
    end else begin
      sgn_s_p2_q <= sgn_s_p1_q;
      sgn_c_p2_q <= sgn_c_p1_q;
      vld_p2_q   <= vld_p1_q;
      sgn_s_p3_q <= sgn_s_p2_q;
      sgn_c_p3_q <= sgn_c_p2_q;
      vld_p3_q   <= vld_p2_q;
    end
  end

  // Stage 4: sign the ROM data when a sample arrives; otherwise keep the last sample.
  always_comb begin
    sin_d   = sin_q;
    cos_d   = cos_q;
    valid_d = vld_p3_q;
    if (vld_p3_q) begin
      sin_d = apply_sign(sgn_s_p3_q, rom_da);
      cos_d = apply_sign(sgn_c_p3_q, rom_db);
    end
  end

  // Output registers. Reset clears them at once, which drops valid in the middle of a stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      valid_q <= valid_d;
    end
  end

  assign rom_aa  = rom_aa_q;
  assign rom_ab  = rom_ab_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_nco_quad.sv
// Directed testbench for nco_quad. It includes a behavioural model of the
// 2-cycle half-sine ROM.
module tb_nco_quad;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic               sync = 1'b0;
  logic [31:0]        freq = '0;
  logic [31:0]        phase_ofs = '0;
  logic [9:0]         rom_aa, rom_ab;
  logic [17:0]        rom_da, rom_db;
  logic signed [18:0] sin_out, cos_out;
  logic               valid;

  int checks = 0;
  int failures = 0;
  int rom [0:1023];

  nco_quad #(.PW(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .freq(freq),
    .phase_ofs(phase_ofs), .rom_aa(rom_aa), .rom_ab(rom_ab),
    .rom_da(rom_da), .rom_db(rom_db), .sin_out(sin_out),
    .cos_out(cos_out), .valid(valid)
  );

  always #5 clk = ~clk;

  // ROM model: the address is latched on one edge and the data is registered on the next.
  logic [9:0] aa_l = '0, ab_l = '0;
  always @(posedge clk) begin
    aa_l   <= rom_aa;
    ab_l   <= rom_ab;
    rom_da <= 18'(rom[aa_l]);
    rom_db <= 18'(rom[ab_l]);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected signed sample for a 32-bit phase value.
  function automatic logic signed [31:0] samp(input logic [31:0] p);
    logic signed [31:0] v;
    v = rom[p[30:21]];
    return p[31] ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; sync = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    logic [31:0] p;
    for (int i = 0; i < 1024; i++)
      rom[i] = $rtoi(262143.0 * $sin(3.14159265358979 * i / 1024.0) + 0.5);
    #1 rst_n = 1'b0;
    tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_sin", 32'(sin_out), 0);
    chk("rst_cos", 32'(cos_out), 0);
    chk("rst_aa", 32'(rom_aa), 0);
    chk("rst_ab", 32'(rom_ab), 0);
    rst_n = 1'b1;
    #2;

    // Continuous sweep with freq=2^21: steps through every ROM address and wraps.
    freq = 32'h0020_0000; phase_ofs = '0; en = 1'b1;
    for (int c = 0; c < 1032; c++) begin
      tick();
      if (c == 0) begin
        chk("t1_aa0", 32'(rom_aa), 0);
        chk("t1_ab0", 32'(rom_ab), 512);
      end
      if (c == 1) chk("t1_aa1", 32'(rom_aa), 1);
      if (c == 1023) chk("t1_aa1023", 32'(rom_aa), 1023);
      if (c == 1024) chk("t1_aa_wrap", 32'(rom_aa), 0);
      if (c < 3) chk("t1_lat_valid", 32'(valid), 0);
      if (c == 3) begin
        chk("t1_first_sin", 32'(sin_out), 0);
        chk("t1_first_cos", 32'(cos_out), 262143);
      end
      if (c == 4) chk("t1_second_sin", 32'(sin_out), 804);
      if (c == 1028) chk("t1_wrap_neg_sin", 32'(sin_out), -804);
      if (c >= 3) begin
        p = 32'(c - 3) << 21;
        chk("t1_valid", 32'(valid), 1);
        chk("t1_sin", 32'(sin_out), samp(p));
        chk("t1_cos", 32'(cos_out), samp(p + 32'h4000_0000));
      end
    end

    // freq=2^31: sine is always 0 and cosine flips sign on every sample.
    do_reset();
    freq = 32'h8000_0000; en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (c >= 3) begin
        chk("t2_valid", 32'(valid), 1);
        chk("t2_sin", 32'(sin_out), 0);
        chk("t2_cos", 32'(cos_out), ((c - 3) % 2 == 0) ? 262143 : -262143);
      end
    end

    // A half-turn offset negates every sample and leaves the latency unchanged.
    do_reset();
    freq = 32'h0020_0000; phase_ofs = 32'h8000_0000; en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 2) chk("t3_lat", 32'(valid), 0);
      if (c == 3) chk("t3_first_cos", 32'(cos_out), -262143);
      if (c >= 3) begin
        p = 32'(c - 3) << 21;
        chk("t3_valid", 32'(valid), 1);
        chk("t3_sin", 32'(sin_out), -samp(p));
        chk("t3_cos", 32'(cos_out), -samp(p + 32'h4000_0000));
      end
    end
    phase_ofs = '0;

    // Gapped enable 1,0,0,1,1: the phase advances only on enabled edges.
    do_reset();
    freq = 32'h0020_0000;
    en = 1'b1; tick();
    en = 1'b0; tick();
    chk("t4_aa_hold", 32'(rom_aa), 0);
    tick();
    en = 1'b1; tick();
    chk("t4_aa_step", 32'(rom_aa), 1);
    chk("t4_v3", 32'(valid), 1);
    chk("t4_s3", 32'(sin_out), 0);
    chk("t4_c3", 32'(cos_out), 262143);
    tick();
    en = 1'b0;
    chk("t4_v4", 32'(valid), 0);
    chk("t4_s4_hold", 32'(sin_out), 0);
    chk("t4_c4_hold", 32'(cos_out), 262143);
    tick();
    chk("t4_v5", 32'(valid), 0);
    tick();
    chk("t4_v6", 32'(valid), 1);
    chk("t4_s6", 32'(sin_out), 804);
    chk("t4_c6", 32'(cos_out), samp(32'h4020_0000));
    tick();
    chk("t4_v7", 32'(valid), 1);
    chk("t4_s7", 32'(sin_out), samp(32'h0040_0000));
    tick();
    chk("t4_v8", 32'(valid), 0);

    // A sync pulse in the middle of the stream, with en held high.
    do_reset();
    freq = 32'h0020_0000; en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      sync = (c == 5);
      tick();
      if (c == 7) chk("t5_pre_sync", 32'(sin_out), samp(32'h0080_0000));
      if (c == 8) chk("t5_gap_valid", 32'(valid), 0);
      if (c == 9) begin
        chk("t5_valid", 32'(valid), 1);
        chk("t5_sin0", 32'(sin_out), 0);
        chk("t5_cos0", 32'(cos_out), 262143);
      end
      if (c == 10) chk("t5_sin1", 32'(sin_out), 804);
    end
    sync = 1'b0;

    // Asynchronous reset between edges while valid is high.
    for (int c = 0; c < 3; c++) tick();
    chk("t6_pre_valid", 32'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(valid), 0);
    chk("t6_async_sin", 32'(sin_out), 0);
    chk("t6_async_cos", 32'(cos_out), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_idle_valid", 32'(valid), 0);
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c < 3) chk("t6_lat_valid", 32'(valid), 0);
      if (c == 3) begin
        chk("t6_first_valid", 32'(valid), 1);
        chk("t6_first_sin", 32'(sin_out), 0);
        chk("t6_first_cos", 32'(cos_out), 262143);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
